execute_muldiv: RTL and testbench
=================================

Name: execute_muldiv

Overview:
Execute-stage multiply/divide unit for the MIPS pipeline. It holds its own decode-to-execute stage register and per-operand forwarding muxes with a parametrised number of bypass sources. It runs signed and unsigned MULT and DIV over several cycles into architectural HI/LO registers, and services MFHI, MFLO, MTHI and MTLO.
- It runs alongside the ALU path.
- `busy` is ORed into the pipeline's execute/decode stall.

Parameters:
- XLEN, 32, data width; HI, LO and operands are each XLEN bits.
- NFWD, 3, number of bypass sources besides the register-file value.
- MUL_LAT, 4, multiply busy cycles; legal range 1..8.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- stall  in  1  hazard stall; stage register holds
- flush  in  1  stage register loads a bubble
- in_valid  in  1  decode presents an instruction
- md_op  in  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO; other codes act as NONE
- rd1, rd2  in  XLEN  register-file operands
- fwd_data  in  NFWD*XLEN  bypass sources; slot k occupies bits [k*XLEN +: XLEN]
- fwd_sel_a, fwd_sel_b  in  $clog2(NFWD+1)  0 selects rd1/rd2; k selects slot k-1; values above NFWD select 0
- md_result  out  XLEN  HI or LO value for MFHI/MFLO
- out_valid  out  1  md_result is valid this cycle
- busy  out  1  unit occupied; upstream must stall
- hi, lo  out  XLEN  architectural HI and LO

Behaviour:
- Reset (asynchronous): stage register cleared (valid 0, op NONE), state IDLE, done 0, HI = LO = 0. Outputs md_result, out_valid and busy are 0.
- Stage register update at posedge:
  - flush: loads a bubble; flush wins over stall.
  - else, when !stall && !busy: loads {in_valid, md_op, rd1, rd2}.
  - otherwise: holds.
  - done is cleared on any load.
- Operands: src_a and src_b are combinational muxes of the registered rd1/rd2 and the live fwd_data. They are sampled only in the issue cycle.
- issue = valid && !done && state == IDLE.
- State machine IDLE / MUL / DIV with a counter cnt:
  - IDLE, issue of MULT/MULTU: latch operands (sign-extend for MULT), cnt = MUL_LAT-1, go to MUL.
  - IDLE, issue of DIV/DIVU: latch |a| and |b| and the sign flags, clear the partial remainder, cnt = XLEN-1, go to DIV.
  - MUL: cnt decrements. At cnt == 0, write {HI,LO} = 2*XLEN-bit product, set done, go to IDLE.
  - DIV: one restoring iteration per cycle. At cnt == 0, apply sign fix, write LO = quotient and HI = remainder, set done, go to IDLE.
    - Quotient is negated if the operand signs differ.
    - Remainder takes the sign of the dividend.
  - MTHI/MTLO on issue: write HI or LO from src_a at the edge, set done; no busy.
  - MFHI/MFLO: out_valid = valid && state == IDLE; md_result = HI or LO. It reflects a write made at the same edge the instruction was loaded.
- busy = (state == IDLE && issue && op is a multiply or divide) || (state != IDLE && cnt != 0).
  - Multiply stalls for MUL_LAT cycles; divide stalls for XLEN cycles.
  - busy is 0 in the completion cycle, so the next instruction loads at the same edge the result is written.
- Divide by zero: LO = all ones, HI = dividend (signed and unsigned); normal latency.
- Signed overflow, most-negative / -1: LO = 0x80000000 (XLEN-scaled), HI = 0.
- Flush during MUL/DIV: only the stage register is bubbled; the in-flight op still completes.
- Stall held across completion: the done flag prevents re-issue; busy stays 0.
- Reset mid-operation: aborts immediately; HI and LO return to 0.

Optional Feature:
MULDIV_MACC_EN
- Defined: adds op codes 9 MADD, 10 MADDU, 11 MSUB, 12 MSUBU.
  - Each has MULT/MULTU timing.
  - At completion: {HI,LO} = {HI,LO} ± product, modulo 2^(2*XLEN), using the HI/LO value present at completion.
- Undefined: codes 9..12 act as NONE; no accumulator adder is synthesised.

Test Plan:
- MULT with a = -3, b = 7 -> busy high for 4 cycles; then HI = 0xFFFFFFFF, LO = 0xFFFFFFEB. MFHI issued next -> out_valid with md_result = 0xFFFFFFFF.
- DIV with -7 / 2 -> busy for 32 cycles; LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIV with 0x80000000 / -1 -> LO = 0x80000000, HI = 0.
- DIVU with 5 / 0 -> LO = 0xFFFFFFFF, HI = 5.
- MULTU with fwd_sel_a = 2 and slot 1 = 6, rd2 = 9. Change slot 1 to 100 one cycle after issue -> LO = 54, HI = 0.
- MULT with stall held for 10 cycles past completion, then flush -> busy asserted exactly 4 cycles total, no re-issue, HI/LO unchanged.
- Reset asserted in cycle 10 of DIVU -> busy = 0 and HI = LO = 0 immediately. Then DIVU with 100 / 7 -> LO = 14, HI = 2.

Source files
------------

// File: rtl/execute_muldiv.sv
// Execute-stage multiply/divide unit: owns its stage register and HI/LO.
// Define MULDIV_MACC_EN to add MADD/MADDU/MSUB/MSUBU accumulate ops.
module execute_muldiv #(
  parameter int XLEN    = 32,
  parameter int NFWD    = 3,
  parameter int MUL_LAT = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        stall,
  input  logic                        flush,
  input  logic                        in_valid,
  input  logic [3:0]                  md_op,
  input  logic [XLEN-1:0]             rd1,
  input  logic [XLEN-1:0]             rd2,
  input  logic [NFWD*XLEN-1:0]        fwd_data,
  input  logic [$clog2(NFWD+1)-1:0]   fwd_sel_a,
  input  logic [$clog2(NFWD+1)-1:0]   fwd_sel_b,
  output logic [XLEN-1:0]             md_result,
  output logic                        out_valid,
  output logic                        busy,
  output logic [XLEN-1:0]             hi,
  output logic [XLEN-1:0]             lo
);

  localparam int SW = $clog2(NFWD+1);
  localparam int CW = $clog2(XLEN > MUL_LAT ? XLEN : MUL_LAT);
  localparam int DW = 2*XLEN;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MULDIV_MACC_EN
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV
  } state_t;

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic            v_q;
  logic [3:0]      op_q;
  logic [XLEN-1:0] rd1_q, rd2_q;
  logic            done_q, done_d;
  logic [XLEN-1:0] hi_q, lo_q;

  logic [DW-1:0]   ma_q, mb_q;
  logic [XLEN-1:0] dq_q, dd_q, dr_q;
  logic            neg_q, neg_r, dzero_q;
`ifdef MULDIV_MACC_EN
  logic            acc_q, sub_q;
`endif

  logic [XLEN-1:0] src_a, src_b;
  logic            load, issue, is_mul, is_div, mul_sgn, div_sgn;
  logic            mul_done, div_done, busy_c;
  logic [DW-1:0]   prod, hilo_n;
  logic [XLEN:0]   dsub;
  logic            qbit;
  logic [XLEN-1:0] dq_n, dr_n, q_fix, r_fix;
  logic            sa, sb;

  function automatic logic [XLEN-1:0] fwd_mux(
    input logic [SW-1:0]        sel,
    input logic [XLEN-1:0]      rf,
    input logic [NFWD*XLEN-1:0] fd
  );
    logic [XLEN-1:0] r;
    r = '0;
    if (sel == '0) r = rf;
    for (int k = 1; k <= NFWD; k++)
      if (sel == SW'(k)) r = fd[(k-1)*XLEN +: XLEN];
    return r;
  endfunction

  always_comb begin
    src_a = fwd_mux(fwd_sel_a, rd1_q, fwd_data);
    src_b = fwd_mux(fwd_sel_b, rd2_q, fwd_data);
  end

  always_comb begin
    is_mul  = (op_q == OP_MULT) || (op_q == OP_MULTU);
    mul_sgn = (op_q == OP_MULT);
`ifdef MULDIV_MACC_EN
    is_mul  = is_mul || (op_q == OP_MADD) || (op_q == OP_MADDU)
           || (op_q == OP_MSUB) || (op_q == OP_MSUBU);
    mul_sgn = mul_sgn || (op_q == OP_MADD) || (op_q == OP_MSUB);
`endif
    is_div  = (op_q == OP_DIV) || (op_q == OP_DIVU);
    div_sgn = (op_q == OP_DIV);
  end

  assign issue    = v_q && !done_q && (state_q == S_IDLE);
  assign load     = flush || (!stall && !busy_c);
  assign mul_done = (state_q == S_MUL) && (cnt_q == '0);
  assign div_done = (state_q == S_DIV) && (cnt_q == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q   <= 1'b0;
      op_q  <= OP_NONE;
      rd1_q <= '0;
      rd2_q <= '0;
    end else if (flush) begin
      v_q   <= 1'b0;
      op_q  <= OP_NONE;
    end else if (!stall && !busy_c) begin
      v_q   <= in_valid;
      op_q  <= md_op;
      rd1_q <= rd1;
      rd2_q <= rd2;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_c  = 1'b0;
    done_d  = done_q;
    unique case (state_q)
      S_IDLE: begin
        busy_c = issue && (is_mul || is_div);
        if (issue && is_mul) begin
          state_d = S_MUL;
          cnt_d   = CW'(MUL_LAT-1);
        end else if (issue && is_div) begin
          state_d = S_DIV;
          cnt_d   = CW'(XLEN-1);
        end
      end
      S_MUL, S_DIV: begin
        busy_c = (cnt_q != '0);
        if (cnt_q == '0) state_d = S_IDLE;
        else cnt_d = cnt_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    // a fresh load always wins so the next instruction can issue
    if (load) done_d = 1'b0;
    else if (mul_done || div_done) done_d = 1'b1;
    else if (issue && (op_q == OP_MTHI || op_q == OP_MTLO)) done_d = 1'b1;
  end

  always_comb begin
    prod = ma_q * mb_q;
`ifdef MULDIV_MACC_EN
    if (acc_q)
      hilo_n = sub_q ? {hi_q, lo_q} - prod : {hi_q, lo_q} + prod;
    else
      hilo_n = prod;
`else
    hilo_n = prod;
`endif
  end

  always_comb begin
    dsub  = {dr_q, dq_q[XLEN-1]} - {1'b0, dd_q};
    qbit  = !dsub[XLEN];
    dr_n  = qbit ? dsub[XLEN-1:0] : {dr_q[XLEN-2:0], dq_q[XLEN-1]};
    dq_n  = {dq_q[XLEN-2:0], qbit};
    q_fix = dzero_q ? '1 : (neg_q ? -dq_n : dq_n);
    r_fix = neg_r ? -dr_n : dr_n;
    sa    = div_sgn && src_a[XLEN-1];
    sb    = div_sgn && src_b[XLEN-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ma_q    <= '0;
      mb_q    <= '0;
      dq_q    <= '0;
      dd_q    <= '0;
      dr_q    <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      dzero_q <= 1'b0;
`ifdef MULDIV_MACC_EN
      acc_q   <= 1'b0;
      sub_q   <= 1'b0;
`endif
    end else begin
      if (issue && is_mul) begin
        ma_q <= {{XLEN{mul_sgn & src_a[XLEN-1]}}, src_a};
        mb_q <= {{XLEN{mul_sgn & src_b[XLEN-1]}}, src_b};
`ifdef MULDIV_MACC_EN
        acc_q <= (op_q >= OP_MADD);
        sub_q <= (op_q == OP_MSUB) || (op_q == OP_MSUBU);
`endif
      end
      if (issue && is_div) begin
        dq_q    <= sa ? -src_a : src_a;
        dd_q    <= sb ? -src_b : src_b;
        dr_q    <= '0;
        neg_q   <= sa ^ sb;
        neg_r   <= sa;
        dzero_q <= (src_b == '0);
      end else if (state_q == S_DIV) begin
        dq_q <= dq_n;
        dr_q <= dr_n;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= done_d;
      if (mul_done) begin
        {hi_q, lo_q} <= hilo_n;
      end else if (div_done) begin
        hi_q <= r_fix;
        lo_q <= q_fix;
      end else if (issue && op_q == OP_MTHI) begin
        hi_q <= src_a;
      end else if (issue && op_q == OP_MTLO) begin
        lo_q <= src_a;
      end
    end
  end

  always_comb begin
    out_valid = v_q && (state_q == S_IDLE)
             && (op_q == OP_MFHI || op_q == OP_MFLO);
    md_result = '0;
    if (out_valid) md_result = (op_q == OP_MFHI) ? hi_q : lo_q;
  end

  assign busy = busy_c;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_execute_muldiv.sv
// Bench for execute_muldiv: vector table, corner sequences, random ops vs model.
module tb_execute_muldiv;

  localparam int XLEN = 32;
  localparam int NFWD = 3;

  logic              clk = 1'b0;
  logic              reset, stall, flush, in_valid;
  logic [3:0]        md_op;
  logic [XLEN-1:0]   rd1, rd2;
  logic [NFWD*XLEN-1:0] fwd_data;
  logic [1:0]        fwd_sel_a, fwd_sel_b;
  logic [XLEN-1:0]   md_result, hi, lo;
  logic              out_valid, busy;

  int checks = 0;
  int failures = 0;

  execute_muldiv #(.XLEN(XLEN), .NFWD(NFWD), .MUL_LAT(4)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .md_op(md_op), .rd1(rd1), .rd2(rd2),
    .fwd_data(fwd_data), .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
    .md_result(md_result), .out_valid(out_valid), .busy(busy),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, ehi, elo;
    int          nb;
  } vec_t;

  vec_t tbl[12];
  logic [63:0] hl;
  int          nb;
  logic        ov;
  logic [31:0] res;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_md(input logic [3:0] op,
      input logic [31:0] a, input logic [31:0] b, input logic [63:0] h);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      4'd1: return 64'(sa * sb);
      4'd2: return {32'b0, a} * {32'b0, b};
      4'd3: if (b == 0) return {a, 32'hFFFFFFFF};
            else return {32'(sa % sb), 32'(sa / sb)};
      4'd4: if (b == 0) return {a, 32'hFFFFFFFF};
            else return {a % b, a / b};
      4'd7: return {a, h[31:0]};
      4'd8: return {h[63:32], a};
      default: return h;
    endcase
  endfunction

  function automatic int exp_busy(input logic [3:0] op);
    if (op == 4'd1 || op == 4'd2) return 4;
    if (op == 4'd3 || op == 4'd4) return XLEN;
    return 0;
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 32'h80000000;
      1: return 32'hFFFFFFFF;
      2: return 32'($urandom_range(0, 3));
      3: return 32'($urandom_range(0, 200));
      default: return $urandom;
    endcase
  endfunction

  task automatic run_op(input logic [3:0] op, input logic [31:0] a,
      input logic [31:0] b, output int n, output logic v,
      output logic [31:0] r);
    in_valid = 1'b1; md_op = op; rd1 = a; rd2 = b;
    step();
    in_valid = 1'b0; md_op = 4'd0;
    v = out_valid; r = md_result;
    n = 0;
    while (busy && n < 200) begin n++; step(); end
    step();
  endtask

  initial begin
    reset = 1'b1; stall = 0; flush = 0; in_valid = 0; md_op = 0;
    rd1 = 0; rd2 = 0; fwd_data = '0; fwd_sel_a = 0; fwd_sel_b = 0;

    tbl[0]  = '{4'd1, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 4};
    tbl[1]  = '{4'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 32};
    tbl[2]  = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 32};
    tbl[3]  = '{4'd4, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 32};
    tbl[4]  = '{4'd3, 32'hFFFFFFF7, 32'd0, 32'hFFFFFFF7, 32'hFFFFFFFF, 32};
    tbl[5]  = '{4'd4, 32'd100, 32'd7, 32'd2, 32'd14, 32};
    tbl[6]  = '{4'd7, 32'h1234, 32'd0, 32'h1234, 32'd14, 0};
    tbl[7]  = '{4'd8, 32'hABCD, 32'd0, 32'h1234, 32'hABCD, 0};
    tbl[8]  = '{4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 4};
    tbl[9]  = '{4'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 4};
    tbl[10] = '{4'd4, 32'hFFFFFFFF, 32'h10, 32'hF, 32'h0FFFFFFF, 32};
    tbl[11] = '{4'd3, 32'd1000, 32'hFFFFFFFD, 32'd1, 32'hFFFFFEB3, 32};

    step(); step();
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ov", 64'(out_valid), 64'd0);
    chk("rst_res", 64'(md_result), 64'd0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 12; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, nb, ov, res);
      chk($sformatf("vec%0d_hi", i), 64'(hi), 64'(tbl[i].ehi));
      chk($sformatf("vec%0d_lo", i), 64'(lo), 64'(tbl[i].elo));
      chk($sformatf("vec%0d_busy", i), 64'(nb), 64'(tbl[i].nb));
    end

    run_op(4'd5, 0, 0, nb, ov, res);
    chk("mfhi_ov", 64'(ov), 64'd1);
    chk("mfhi_res", 64'(res), 64'd1);

    // MFLO waiting upstream loads on the same edge MULT writes LO
    in_valid = 1; md_op = 4'd1; rd1 = 32'hFFFFFFFD; rd2 = 32'd7;
    step();
    md_op = 4'd6;
    nb = 0;
    while (busy && nb < 200) begin nb++; step(); end
    step();
    chk("mf_after_ov", 64'(out_valid), 64'd1);
    chk("mf_after_res", 64'(md_result), 64'hFFFFFFEB);
    in_valid = 0; md_op = 0;
    step();

    // forwarding: operands captured in the issue cycle only
    in_valid = 1; md_op = 4'd2; rd1 = 32'd77; rd2 = 32'd9;
    fwd_sel_a = 2'd2; fwd_data = '0; fwd_data[32 +: 32] = 32'd6;
    step();
    in_valid = 0; md_op = 0;
    step();
    fwd_data[32 +: 32] = 32'd100;
    nb = 0;
    while (busy && nb < 200) begin nb++; step(); end
    step();
    chk("fwd_a_lo", 64'(lo), 64'd54);
    chk("fwd_a_hi", 64'(hi), 64'd0);
    fwd_sel_a = 0;

    fwd_sel_b = 2'd3; fwd_data[64 +: 32] = 32'hFFFFFFFE;
    run_op(4'd1, 32'd5, 32'd1, nb, ov, res);
    chk("fwd_b_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFF6);
    fwd_sel_b = 0;

    // stall across completion, then flush
    in_valid = 1; md_op = 4'd1; rd1 = 32'd5; rd2 = 32'd6;
    step();
    in_valid = 0; md_op = 0; stall = 1;
    nb = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy) nb++;
      step();
    end
    chk("stall_hilo", {hi, lo}, 64'd30);
    flush = 1; step(); flush = 0; stall = 0;
    for (int i = 0; i < 4; i++) begin
      if (busy) nb++;
      step();
    end
    chk("stall_busy", 64'(nb), 64'd4);
    chk("stall_hilo2", {hi, lo}, 64'd30);

    // flush mid-divide does not abort the divide
    in_valid = 1; md_op = 4'd3; rd1 = 32'hFFFFFC18; rd2 = 32'd7;
    step();
    in_valid = 0; md_op = 0;
    nb = 0;
    while (busy && nb < 200) begin nb++; flush = (nb == 5); step(); end
    flush = 0;
    step();
    chk("fdiv_busy", 64'(nb), 64'd32);
    chk("fdiv_hilo", {hi, lo},
        ref_md(4'd3, 32'hFFFFFC18, 32'd7, 64'd0));

    // reset in the middle of DIVU
    in_valid = 1; md_op = 4'd4; rd1 = 32'd1000; rd2 = 32'd3;
    step();
    in_valid = 0; md_op = 0;
    repeat (9) step();
    chk("rdiv_busy_pre", 64'(busy), 64'd1);
    reset = 1;
    #1;
    chk("rdiv_busy", 64'(busy), 64'd0);
    chk("rdiv_hilo", {hi, lo}, 64'd0);
    step();
    reset = 0;
    step();
    run_op(4'd4, 32'd100, 32'd7, nb, ov, res);
    chk("rdiv_after", {hi, lo}, {32'd2, 32'd14});

`ifndef MULDIV_MACC_EN
    hl = {hi, lo};
    run_op(4'd9, 32'd3, 32'd4, nb, ov, res);
    chk("op9_none", {hi, lo}, hl);
    chk("op9_busy", 64'(nb), 64'd0);
`endif

    hl = {hi, lo};
    for (int i = 0; i < 40; i++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      logic [63:0] e;
      op = 4'($urandom_range(1, 8));
      a = rnd_val();
      b = rnd_val();
      e = ref_md(op, a, b, hl);
      run_op(op, a, b, nb, ov, res);
      chk($sformatf("rnd%0d_op%0d_hilo", i, op), {hi, lo}, e);
      chk($sformatf("rnd%0d_busy", i), 64'(nb), 64'(exp_busy(op)));
      if (op == 4'd5 || op == 4'd6) begin
        chk($sformatf("rnd%0d_ov", i), 64'(ov), 64'd1);
        chk($sformatf("rnd%0d_res", i), 64'(res),
            64'(op == 4'd5 ? hl[63:32] : hl[31:0]));
      end else begin
        chk($sformatf("rnd%0d_ov", i), 64'(ov), 64'd0);
      end
      hl = e;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
